// File: rtl/systolic_mac_sequencer.sv
// Tile sequencer for the NxN systolic MAC array: clear, feed K operand slices,
// flush the skew/multiplier pipeline, then drain result rows over valid/ready.
module systolic_mac_sequencer #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned KW       = 8,
  parameter  int unsigned MULT_LAT = 3,
  localparam int unsigned RW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          busy,
  output logic          pe_clr,
  output logic          feed_en,
  output logic [KW-1:0] k_idx,
  output logic          acc_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic          done
);

  localparam int unsigned FLUSH_CYC = 2 * (N - 1) + MULT_LAT + 1;
  localparam int unsigned FW        = $clog2(FLUSH_CYC);
  localparam int unsigned CW        = (KW > FW) ? KW : FW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_lat;
  logic [CW-1:0] cnt;

  logic last_feed;
  logic last_flush;
  logic row_accept;
  logic last_row;

  // Shared counter: inner index during FEED, pipeline depth during FLUSH.
  assign last_feed  = (cnt == (CW'(k_lat) - CW'(1)));
  assign last_flush = (cnt == CW'(FLUSH_CYC - 1));
  assign row_accept = out_valid & out_ready;
  assign last_row   = (out_row == RW'(N - 1));

  // Outputs are a registered decode of the state held during the previous cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      pe_clr    <= 1'b0;
      feed_en   <= 1'b0;
      k_idx     <= '0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      done      <= 1'b0;
    end else begin
      busy    <= (state != S_IDLE) && (state != S_DONE);
      pe_clr  <= 1'b0;
      feed_en <= 1'b0;
      k_idx   <= '0;
      acc_en  <= 1'b0;
      done    <= 1'b0;

      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          out_row   <= '0;
          if (start) begin
            k_lat <= k_len;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pe_clr <= 1'b1;
          cnt    <= '0;
          state  <= (k_lat != '0) ? S_FEED : S_FLUSH;
        end
        S_FEED: begin
          feed_en <= 1'b1;
          acc_en  <= 1'b1;
          k_idx   <= KW'(cnt);
          if (last_feed) begin
            cnt   <= '0;
            state <= S_FLUSH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FLUSH: begin
          acc_en <= 1'b1;
          if (last_flush) begin
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          // First cycle here raises out_valid; later cycles follow the handshake.
          if (row_accept) begin
            if (last_row) begin
              out_valid <= 1'b0;
              out_row   <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              out_row <= out_row + RW'(1);
            end
          end else begin
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          out_row   <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Abort wins over any transition, and a tile that is cancelled never reports done.
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_sequencer.sv
// Self-checking bench for systolic_mac_sequencer: per-cycle comparison of all
// outputs against a timeline model derived from the tile schedule.
module tb_systolic_mac_sequencer;

  localparam int unsigned N        = 4;
  localparam int unsigned KW       = 8;
  localparam int unsigned MULT_LAT = 3;
  localparam int unsigned RW       = 2;
  localparam int          F        = 2 * (N - 1) + MULT_LAT + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          pe_clr;
  logic          feed_en;
  logic [KW-1:0] k_idx;
  logic          acc_en;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic          done;

  int errors = 0;
  int checks = 0;

  systolic_mac_sequencer #(.N(N), .KW(KW), .MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .pe_clr    (pe_clr),
    .feed_en   (feed_en),
    .k_idx     (k_idx),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Runs one tile (edge 0 samples start) and checks every output at every edge.
  // The model places each phase on the edge timeline: pe_clr at 1, feed at 2..K+1,
  // accumulate through K+1+F, rows presented from K+2+F and advanced on accepted edges.
  task automatic run_tile(input int k, input bit rnd_ready, input int stall_row,
                          input int stall_len, input int abort_at, input bit repulse,
                          input bit late_start, input bit rst_mid, output int done_e);
    int row, stalled, d0, e_k, er;
    bit vld, dn, fin, rdy_cur, rst_cur, zero;
    bit e_busy, e_pe, e_feed, e_acc, ev;
    d0 = 2 + k + F; done_e = -1; row = 0; vld = 0; stalled = 0; fin = 0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; k_len = KW'(k); abort = 1'b0; out_ready = 1'b1;
    for (int e = 0; e < 1000 && !fin; e++) begin
      rdy_cur = out_ready;
      rst_cur = !rst;
      @(posedge clk); #1;
      zero = rst_cur || (abort_at >= 0 && e > abort_at);
      dn = 1'b0;
      if (!zero) begin
        if (e == d0) begin
          vld = 1'b1; row = 0;
        end else if (e > d0 && vld && rdy_cur) begin
          if (row == N - 1) begin
            vld = 1'b0; row = 0; dn = 1'b1; done_e = e;
          end else begin
            row++;
          end
        end
      end
      e_busy = !zero && e >= 1 && (done_e < 0 || e <= done_e);
      e_pe   = !zero && e == 1;
      e_feed = !zero && e >= 2 && e <= 1 + k;
      e_k    = e_feed ? e - 2 : 0;
      e_acc  = !zero && e >= 2 && e <= 1 + k + F;
      ev     = !zero && vld;
      er     = ev ? row : 0;
      checks++;
      if (busy !== e_busy || pe_clr !== e_pe || feed_en !== e_feed || k_idx !== KW'(e_k) ||
          acc_en !== e_acc || out_valid !== ev || out_row !== RW'(er) || done !== dn) begin
        errors++;
        $display("FAIL cycle %0d K=%0d: got busy=%b pe_clr=%b feed_en=%b k_idx=%0d acc_en=%b out_valid=%b out_row=%0d done=%b; required %b %b %b %0d %b %b %0d %b",
                 e, k, busy, pe_clr, feed_en, k_idx, acc_en, out_valid, out_row, done,
                 e_busy, e_pe, e_feed, e_k, e_acc, ev, er, dn);
      end
      if (rst_cur || (abort_at >= 0 && e == abort_at + 2) ||
          (done_e >= 0 && e == done_e + (late_start ? 2 : 1)))
        fin = 1'b1;
      if (!fin) begin
        @(negedge clk);
        start = 1'b0; k_len = KW'($urandom); rst = 1'b1; out_ready = 1'b1;
        abort = (abort_at >= 0 && e + 1 == abort_at);
        if (repulse && e + 1 == 3) begin start = 1'b1; k_len = KW'(7); end
        if (late_start && done_e == e) begin start = 1'b1; k_len = KW'(5); end
        if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
        if (stall_len > 0 && vld && row == stall_row && stalled < stall_len) begin
          out_ready = 1'b0; stalled++;
        end
        if (rst_mid && vld && row == 1) rst = 1'b0;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout K=%0d: tile did not complete within 1000 cycles", k);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({busy, pe_clr, feed_en, acc_en, out_valid, done} !== 6'b0 || k_idx !== '0 || out_row !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b pe_clr=%b feed_en=%b acc_en=%b out_valid=%b done=%b k_idx=%0d out_row=%0d; required all 0",
               name, busy, pe_clr, feed_en, acc_en, out_valid, done, k_idx, out_row);
    end
  endtask

  task automatic check_done_at(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: done at cycle %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; k_len = KW'(3); abort = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check_idle("post_reset_idle");
  endtask

  task automatic test_nominal();
    int d;
    run_tile(3, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("nominal", d, 19);
  endtask

  task automatic test_backpressure();
    int d;
    run_tile(3, 0, 2, 5, -1, 0, 0, 0, d);
    check_done_at("backpressure", d, 24);
  endtask

  task automatic test_k_zero();
    int d;
    run_tile(0, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("k_zero", d, 16);
  endtask

  task automatic test_start_repulse();
    int d;
    run_tile(3, 0, -1, 0, -1, 1, 0, 0, d);
    check_done_at("start_repulse", d, 19);
  endtask

  task automatic test_abort();
    int d;
    run_tile(3, 0, -1, 0, 3, 0, 0, 0, d);
    check_done_at("abort_no_done", d, -1);
    run_tile(3, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("after_abort", d, 19);
  endtask

  task automatic test_back_to_back();
    int d;
    run_tile(2, 0, -1, 0, -1, 0, 1, 0, d);
    check_done_at("start_in_done", d, 18);
    run_tile(1, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("back_to_back", d, 17);
  endtask

  task automatic test_reset_mid_drain();
    int d;
    run_tile(4, 0, -1, 0, -1, 0, 0, 1, d);
    check_done_at("reset_mid_drain", d, -1);
    run_tile(3, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("after_reset", d, 19);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 8; i++) begin
      run_tile(int'($urandom_range(0, 20)), 1, -1, 0, -1, 0, 0, 0, d);
    end
  endtask

  task automatic test_k_max();
    int d;
    run_tile(255, 0, -1, 0, -1, 0, 0, 0, d);
    check_done_at("k_max", d, 271);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_k_zero();
    test_start_repulse();
    test_abort();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    test_k_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
